// File: rtl/reglist_transfer_sequencer.sv
// reglist_transfer_sequencer
// Sequences PUSH / POP / STMIA / LDMIA for the Cortex-M0 core. It walks the
// register list from the lowest set bit upward and moves one word per memory
// handshake at ascending word addresses. It finishes with a one-cycle
// base-register writeback. For POP {..,PC}, the PC slot produces a PC load
// strobe instead of a register-file write.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   start, op            launch strobe (sampled only when idle), operation code
//   reg_list, rn_idx     register list (bit 8 = LR/PC), STM/LDM base register
//   base_val             SP or Rn value, sampled with start
//   busy, done, error    status: busy window, completion pulse, empty-list pulse
//   mem_req/we/addr/wdata, mem_rdata, mem_ready   data-memory handshake port
//   rf_raddr, rf_rdata   register-file read port (store data source)
//   rf_we/waddr/wdata    register-file write port (loads and base writeback)
//   pc_ld, pc_wdata      PC load strobe and value (bit 0 cleared)
module reglist_transfer_sequencer #(
  parameter int         ADDR_W = 32,
  parameter logic [3:0] SP_IDX = 4'hd,
  parameter logic [3:0] LR_IDX = 4'he
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [8:0]        reg_list,
  input  logic [2:0]        rn_idx,
  input  logic [ADDR_W-1:0] base_val,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [3:0]        rf_raddr,
  input  logic [31:0]       rf_rdata,
  output logic              rf_we,
  output logic [3:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              pc_ld,
  output logic [31:0]       pc_wdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_WB = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(32'd4);

  function automatic logic [3:0] popcnt9(input logic [8:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 9; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Index of the lowest set bit; 0 for an empty vector.
  function automatic logic [3:0] low_idx(input logic [8:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 8; i >= 0; i--) if (v[i]) idx = i[3:0];
    return idx;
  endfunction

  state_t            state_q;
  logic [8:0]        list_q;
  logic [1:0]        op_q;
  logic [2:0]        rn_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_fin_q;
  logic              wb_sup_q;
  logic              busy_q, done_q, error_q, mem_req_q, mem_we_q;

  logic [8:0]        eff_list_s;
  logic [3:0]        n_s;
  logic [ADDR_W-1:0] span_s;
  logic [3:0]        cur_idx_s;
  logic [8:0]        list_d;
  logic              pc_slot_s;
  logic [3:0]        reg_idx_s;

  // Bit 8 means nothing for STM/LDM, so it is masked before counting.
  assign eff_list_s = op[1] ? {1'b0, reg_list[7:0]} : reg_list;
  assign n_s        = popcnt9(eff_list_s);
  assign span_s     = ADDR_W'({n_s, 2'b00});
  assign cur_idx_s  = low_idx(list_q);
  assign list_d     = list_q & ~(9'd1 << cur_idx_s);
  assign pc_slot_s  = (cur_idx_s == 4'd8) && (op_q == 2'b01);
  assign reg_idx_s  = (cur_idx_s == 4'd8) ? LR_IDX : {1'b0, cur_idx_s[2:0]};

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign mem_req  = mem_req_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = addr_q;

  // Register-file / PC side effects: load writes land in the completing cycle.
  always_comb begin
    rf_raddr  = 4'd0;
    mem_wdata = 32'd0;
    rf_we     = 1'b0;
    rf_waddr  = 4'd0;
    rf_wdata  = 32'd0;
    pc_ld     = 1'b0;
    pc_wdata  = 32'd0;
    if (state_q == S_XFER) begin
      rf_raddr  = reg_idx_s;
      mem_wdata = mem_we_q ? rf_rdata : 32'd0;
      if (!mem_we_q && mem_ready) begin
        if (pc_slot_s) begin
          pc_ld    = 1'b1;
          pc_wdata = mem_rdata & ~32'd1;
        end else begin
          rf_we    = 1'b1;
          rf_waddr = reg_idx_s;
          rf_wdata = mem_rdata;
        end
      end else begin
        rf_we = 1'b0;
      end
    end else if (state_q == S_WB) begin
      rf_we    = ~wb_sup_q;
      rf_waddr = op_q[1] ? {1'b0, rn_q} : SP_IDX;
      rf_wdata = 32'(base_fin_q);
    end else begin
      rf_we = 1'b0;
    end
  end

  // Sequencer FSM with registered status and memory-request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      list_q     <= 9'd0;
      op_q       <= 2'd0;
      rn_q       <= 3'd0;
      addr_q     <= '0;
      base_fin_q <= '0;
      wb_sup_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q    <= 1'b0;
          mem_req_q <= 1'b0;
          if (busy_q) begin
            // Error-pulse cycle: still busy, so start is ignored here.
            busy_q  <= 1'b0;
            error_q <= 1'b0;
          end else if (start) begin
            busy_q <= 1'b1;
            if (n_s == 4'd0) begin
              error_q <= 1'b1;
            end else begin
              state_q    <= S_XFER;
              list_q     <= eff_list_s;
              op_q       <= op;
              rn_q       <= rn_idx;
              addr_q     <= (op == 2'b00) ? base_val - span_s : base_val;
              base_fin_q <= (op == 2'b00) ? base_val - span_s : base_val + span_s;
              wb_sup_q   <= (op == 2'b11) && eff_list_s[rn_idx];
              mem_req_q  <= 1'b1;
              mem_we_q   <= ~op[0];
            end
          end else begin
            error_q <= 1'b0;
          end
        end
        S_XFER: begin
          if (mem_ready) begin
            list_q <= list_d;
            addr_q <= addr_q + WORD_STEP;
            if (list_d == 9'd0) begin
              state_q   <= S_WB;
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          error_q   <= 1'b0;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reglist_transfer_sequencer.sv
// Scoreboard bench for reglist_transfer_sequencer: directed vectors push
// hand-computed events, a negedge monitor pops and compares them.
module tb_reglist_transfer_sequencer;

  localparam int K_LD = 0, K_ST = 1, K_RF = 2, K_PC = 3, K_DONE = 4, K_ERR = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [8:0]  reg_list = 9'd0;
  logic [2:0]  rn_idx = 3'd0;
  logic [31:0] base_val = 32'd0;
  logic        mem_ready = 1'b1;
  logic        busy, done, error, mem_req, mem_we, rf_we, pc_ld;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rf_rdata, rf_wdata, pc_wdata;
  logic [3:0]  rf_raddr, rf_waddr;

  logic [31:0] rf_m  [0:15];
  logic [31:0] mem_m [0:255];

  assign rf_rdata  = rf_m[rf_raddr];
  assign mem_rdata = mem_m[mem_addr[9:2]];

  always #5 clk = ~clk;

  reglist_transfer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .reg_list(reg_list),
    .rn_idx(rn_idx), .base_val(base_val), .busy(busy), .done(done),
    .error(error), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc_ld(pc_ld),
    .pc_wdata(pc_wdata)
  );

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_ev(input int k, input logic [31:0] a, input logic [31:0] d, input bit cmp_d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d addr 0x%08h data 0x%08h, expected none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", k, e.kind);
      chk("ev_addr", a, e.a);
      if (cmp_d) chk("ev_data", d, e.d);
    end
  endtask

  // Monitor: every observable DUT event is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_ready) pop_ev(mem_we ? K_ST : K_LD, mem_addr, mem_wdata, mem_we);
      if (rf_we) pop_ev(K_RF, {28'd0, rf_waddr}, rf_wdata, 1'b1);
      if (pc_ld) pop_ev(K_PC, 32'd0, pc_wdata, 1'b1);
      if (done)  pop_ev(K_DONE, 32'd0, 32'd0, 1'b0);
      if (error) pop_ev(K_ERR, 32'd0, 32'd0, 1'b0);
    end
  end

  task automatic launch(input logic [1:0] o, input logic [8:0] l, input logic [2:0] rn, input logic [31:0] b);
    @(posedge clk); #1;
    op = o; reg_list = l; rn_idx = rn; base_val = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done/error; cyc = cycle index of that pulse after start.
  task automatic wait_end(output int cyc, output int busy_n, output int req_n);
    bit fin;
    fin = 1'b0; cyc = 1; busy_n = 0; req_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (mem_req) req_n++;
      if (done || error) begin
        fin = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    if (!fin) begin
      checks++;
      $display("FAIL timeout: got no done/error within 40 cycles, expected one");
    end
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic push_test1();
    expect_ev(K_ST, 32'hF4, 32'hA);
    expect_ev(K_ST, 32'hF8, 32'hB);
    expect_ev(K_ST, 32'hFC, 32'hFFFF_FFFF);
    expect_ev(K_RF, 32'hD, 32'hF4);
    expect_ev(K_DONE, 32'd0, 32'd0);
  endtask

  int cyc, busy_n, req_n;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) rf_m[i] = 32'h1000_0000 + i;
    for (int i = 0; i < 256; i++) mem_m[i] = 32'hDEAD_0000 + i;
    rf_m[0] = 32'hA; rf_m[1] = 32'hB; rf_m[2] = 32'h22; rf_m[3] = 32'h33;
    rf_m[14] = 32'hFFFF_FFFF;
    mem_m[8'h3D] = 32'h55; mem_m[8'h3E] = 32'h201;
    mem_m[8'h10] = 32'h1111; mem_m[8'h11] = 32'h3333;

    // Reset state
    #12;
    chk("reset_ctrl", {25'd0, busy, done, error, mem_req, mem_we, rf_we, pc_ld}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_pc_wdata", pc_wdata, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: PUSH {R0,R1,LR} from SP=0x100
    push_test1();
    launch(2'b00, 9'h103, 3'd0, 32'h100);
    wait_end(cyc, busy_n, req_n);
    chk("t1_done_cycle", cyc, 32'd4);
    chk("t1_busy_cycles", busy_n, 32'd4);
    chk("t1_req_cycles", req_n, 32'd3);
    chk("t1_queue_empty", exp_q.size(), 32'd0);

    // 2: POP {R2,PC} from SP=0xF4
    expect_ev(K_LD, 32'hF4, 32'd0);
    expect_ev(K_RF, 32'h2, 32'h55);
    expect_ev(K_LD, 32'hF8, 32'd0);
    expect_ev(K_PC, 32'd0, 32'h200);
    expect_ev(K_RF, 32'hD, 32'hFC);
    expect_ev(K_DONE, 32'd0, 32'd0);
    launch(2'b01, 9'h104, 3'd0, 32'hF4);
    wait_end(cyc, busy_n, req_n);
    chk("t2_done_cycle", cyc, 32'd3);
    chk("t2_queue_empty", exp_q.size(), 32'd0);

    // 3: LDMIA R1!,{R1,R3} (bit 8 set but masked), writeback suppressed
    expect_ev(K_LD, 32'h40, 32'd0);
    expect_ev(K_RF, 32'h1, 32'h1111);
    expect_ev(K_LD, 32'h44, 32'd0);
    expect_ev(K_RF, 32'h3, 32'h3333);
    expect_ev(K_DONE, 32'd0, 32'd0);
    launch(2'b11, 9'h10A, 3'd1, 32'h40);
    wait_end(cyc, busy_n, req_n);
    chk("t3_done_cycle", cyc, 32'd3);
    chk("t3_queue_empty", exp_q.size(), 32'd0);

    // 4: STMIA R2!,{R0} with three wait states
    expect_ev(K_ST, 32'h80, 32'hA);
    expect_ev(K_RF, 32'h2, 32'h84);
    expect_ev(K_DONE, 32'd0, 32'd0);
    mem_ready = 1'b0;
    launch(2'b10, 9'h001, 3'd2, 32'h80);
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) mem_ready = 1'b1;
      @(negedge clk);
      chk("t4_hold_req", {31'd0, mem_req}, 32'd1);
      chk("t4_hold_addr", mem_addr, 32'h80);
      chk("t4_hold_wdata", mem_wdata, 32'hA);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t4_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // 5: empty effective lists raise error only
    expect_ev(K_ERR, 32'd0, 32'd0);
    launch(2'b00, 9'h000, 3'd0, 32'h100);
    wait_end(cyc, busy_n, req_n);
    chk("t5a_err_cycle", cyc, 32'd1);
    chk("t5a_busy_cycles", busy_n, 32'd1);
    chk("t5a_no_req", req_n, 32'd0);
    expect_ev(K_ERR, 32'd0, 32'd0);
    launch(2'b10, 9'h100, 3'd3, 32'h100);
    wait_end(cyc, busy_n, req_n);
    chk("t5b_err_cycle", cyc, 32'd1);
    chk("t5b_no_req", req_n, 32'd0);
    chk("t5_queue_empty", exp_q.size(), 32'd0);

    // 6: reset during the 2nd transfer of a 4-register PUSH
    expect_ev(K_ST, 32'h1F0, 32'hA);
    launch(2'b00, 9'h00F, 3'd0, 32'h200);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_req_drop", {31'd0, mem_req}, 32'd0);
    chk("t6_busy_drop", {31'd0, busy}, 32'd0);
    chk("t6_rfwe_drop", {31'd0, rf_we}, 32'd0);
    chk("t6_addr_clear", mem_addr, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_queue_empty", exp_q.size(), 32'd0);
    push_test1();
    launch(2'b00, 9'h103, 3'd0, 32'h100);
    wait_end(cyc, busy_n, req_n);
    chk("t6_rerun_done_cycle", cyc, 32'd4);
    chk("t6_rerun_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
